dmem_ctrl: RTL and testbench

Data-memory access controller between the EX stage and the data SRAM port used by MEM. It accepts one load/store per instruction, builds byte enables and lane-aligned write data, and sequences a variable-latency SRAM handshake. It holds `stallreq` high to the stall controller until the access completes, then returns extended load data for MEM to forward to WB and ID.

---
 rtl/dmem_ctrl_pkg.sv | 10 +
 rtl/dmem_lane.sv | 23 ++
 rtl/dmem_ctrl.sv | 77 +++++++
 tb/tb_dmem_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared size codes, FSM states and alignment check for the data-memory controller
package dmem_ctrl_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [1:0] {DM_IDLE, DM_ACCESS, DM_DONE} dm_state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00) || size == 2'b11;
  endfunction
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: byte-enable, store lane replication and load lane select/extend
module dmem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        sgn,
  output logic [3:0]  wen,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    wen = size == SZ_B ? 4'b0001 << off : size == SZ_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_al = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    rdata_ext = size == SZ_B ? {{24{sgn & b[7]}}, b} : size == SZ_H ? {{16{sgn & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: EX-to-SRAM data-memory access sequencer with pipeline stall request
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             stallreq,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_misalign,
  output logic             sram_en,
  output logic [3:0]       sram_wen,
  output logic [31:0]      sram_addr,
  output logic [31:0]      sram_wdata,
  input  logic             sram_ready,
  input  logic [31:0]      sram_rdata,
  output logic [CNT_W-1:0] stall_cnt
);
  dm_state_t state, state_nxt;
  logic we_r, sgn_r, mis_r, acc, done;
  logic [1:0] size_r;
  logic [31:0] addr_r, wdata_r, rdata_r, wdata_al, rdata_ext;
  logic [3:0] wen;
  dmem_lane u_lane (
    .size(size_r), .off(addr_r[1:0]), .wdata(wdata_r), .rdata(rdata_r), .sgn(sgn_r),
    .wen(wen), .wdata_al(wdata_al), .rdata_ext(rdata_ext)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= DM_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == DM_IDLE ? (req_valid ? (misaligned(req_size, req_addr[1:0]) ? DM_DONE : DM_ACCESS) : DM_IDLE) :
                state == DM_ACCESS ? (sram_ready ? DM_DONE : DM_ACCESS) : DM_IDLE;
  always_comb begin
    acc = state == DM_ACCESS;
    done = state == DM_DONE;
    stallreq = !rst && (state == DM_IDLE ? req_valid : acc);
    sram_en = acc;
    sram_wen = acc && we_r ? wen : 4'b0000;
    sram_addr = acc ? {addr_r[31:2], 2'b00} : 32'h0;
    sram_wdata = acc ? wdata_al : 32'h0;
    resp_valid = done;
    resp_misalign = done && mis_r;
    resp_rdata = done && !we_r && !mis_r ? rdata_ext : 32'h0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_r <= 1'b0;
      sgn_r <= 1'b0;
      mis_r <= 1'b0;
      size_r <= 2'b00;
      addr_r <= 32'h0;
      wdata_r <= 32'h0;
      rdata_r <= 32'h0;
    end else begin
      if (state == DM_IDLE && req_valid) begin
        we_r <= req_we;
        sgn_r <= req_signed;
        mis_r <= misaligned(req_size, req_addr[1:0]);
        size_r <= req_size;
        addr_r <= req_addr;
        wdata_r <= req_wdata;
      end
      if (acc && sram_ready) rdata_r <= sram_rdata;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (stallreq && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed stimulus with per-cycle expectations and a response scoreboard
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;
  logic clk = 1'b0, rst, req_valid, req_we, req_signed, sram_ready;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, sram_rdata;
  logic stallreq, resp_valid, resp_misalign, sram_en;
  logic [31:0] resp_rdata, sram_addr, sram_wdata;
  logic [3:0] sram_wen;
  logic [2:0] stall_cnt, cnt_m;
  logic e_stall, e_rv, e_en, done;
  logic [3:0] e_wen;
  logic [31:0] e_addr, e_wd;
  logic [32:0] q[$];
  logic [32:0] e;
  logic [70:0] act, expv;
  int checks = 0, failures = 0;
  dmem_ctrl #(.CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .stallreq(stallreq),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ready(sram_ready), .sram_rdata(sram_rdata), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic s, rv, en, input logic [3:0] w, input logic [31:0] a, wd);
    e_stall = s; e_rv = rv; e_en = en; e_wen = w; e_addr = a; e_wd = wd;
  endtask
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, wd,
                      input int lat, input logic [31:0] rd, input logic [3:0] ewen,
                      input logic [31:0] ewd, erd, input logic hold);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    q.push_back({1'b0, erd});
    tick;
    if (!hold) begin
      req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_we = ~we;
    end
    for (int i = 1; i <= lat; i++) begin
      sram_ready = i == lat;
      sram_rdata = i == lat ? rd : 32'h5555AAAA;
      ex(1'b1, 1'b0, 1'b1, ewen, {a[31:2], 2'b00}, ewd);
      tick;
    end
    sram_ready = 1'b0;
    ex(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    tick;
  endtask
  always @(negedge clk) begin
    if (rst) cnt_m = 3'd0;
    act = {stallreq, resp_valid, sram_en, sram_wen, sram_addr, sram_wdata};
    expv = {e_stall, e_rv, e_en, e_wen, e_addr, e_wd};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL cycle t=%0t got=%h want=%h", $time, act, expv);
    end
    checks++;
    if (stall_cnt !== cnt_m) begin
      failures++;
      $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, cnt_m);
    end
    if (resp_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected t=%0t rdata=%h misalign=%b", $time, resp_rdata, resp_misalign);
      end else begin
        e = q.pop_front();
        if (resp_misalign !== e[32] || (!e[32] && resp_rdata !== e[31:0])) begin
          failures++;
          $display("FAIL resp t=%0t got=%b/%h want=%b/%h", $time, resp_misalign, resp_rdata, e[32], e[31:0]);
        end
      end
    end
    if (!rst && e_stall && cnt_m != 3'd7) cnt_m = cnt_m + 3'd1;
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL resp_missing got=%0d pending want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end
  initial begin
    rst = 1'b1; done = 1'b0; cnt_m = 3'd0;
    req_valid = 1'b0; req_we = 1'b0; req_size = SZ_B; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; sram_ready = 1'b0; sram_rdata = 32'h0;
    ex(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    xact(1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
    sram_ready = 1'b1; sram_rdata = 32'h11111111;
    ex(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    sram_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_signed = 1'b0; req_addr = 32'h101;
    ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    q.push_back({1'b1, 32'h0});
    tick;
    req_valid = 1'b0;
    ex(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    xact(1'b0, SZ_B, 1'b1, 32'h103, 32'h0, 1, 32'h80FF1234, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0);
    xact(1'b0, SZ_B, 1'b0, 32'h103, 32'h0, 1, 32'h80FF1234, 4'b0000, 32'h0, 32'h00000080, 1'b0);
    xact(1'b1, SZ_H, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
    xact(1'b0, SZ_H, 1'b1, 32'h602, 32'h0, 2, 32'h80017FFF, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h500; req_wdata = 32'h0;
    ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    req_valid = 1'b0;
    ex(1'b1, 1'b0, 1'b1, 4'h0, 32'h500, 32'h0);
    tick;
    rst = 1'b1;
    ex(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    rst = 1'b0; sram_ready = 1'b1; sram_rdata = 32'h12345678;
    tick;
    sram_ready = 1'b0;
    tick;
    xact(1'b1, SZ_B, 1'b0, 32'h401, 32'h0000005A, 1, 32'h0, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0);
    xact(1'b0, SZ_W, 1'b0, 32'h300, 32'h0, 1, 32'hCAFEF00D, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b1);
    xact(1'b0, SZ_B, 1'b1, 32'h305, 32'h0, 2, 32'h1234C378, 4'b0000, 32'h0, 32'hFFFFFFC3, 1'b0);
    ex(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick;
    done = 1'b1;
  end
endmodule
